// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and
// instruction memory. The fetch stage is the master.
interface if_stage_if #(
  parameter int size = 32
) ();
  logic            imem_req;
  logic [size-1:0] imem_addr;
  logic            imem_ack;
  logic [size-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over req/ack,
// and feeds the IF/ID register, with stall, redirect squash and a one-entry hold buffer.
module if_stage #(
  parameter int              size     = 32,
  parameter logic [size-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            stall,
  input  logic            redirect,
  input  logic [size-1:0] redirect_pc,
  if_stage_if.master      imem,
  output logic [size-1:0] PC_IF,
  output logic [size-1:0] idata_IF,
  output logic            valid_IF
);

  typedef enum logic [1:0] {REQ, DRAIN, HOLD} state_t;

  localparam logic [size-1:0] inc = size'(4);

  state_t          state, state_d;
  logic [size-1:0] pc, pc_d;
  logic [size-1:0] req_addr, req_addr_d;
  logic [size-1:0] hold_data, hold_data_d;
  logic [size-1:0] hold_pc, hold_pc_d;
  logic [size-1:0] pc_if_d, idata_d;
  logic            valid_d;
  logic [size-1:0] target;
  logic            ack;

  assign target = redirect_pc & ~{{(size-2){1'b0}}, 2'b11};

  // The request is gated by reset so it drops the instant reset asserts.
  assign imem.imem_req  = RESET_N && (state != HOLD);
  assign imem.imem_addr = req_addr;
  assign ack            = imem.imem_req && imem.imem_ack;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d     = state;
    pc_d        = pc;
    req_addr_d  = req_addr;
    hold_data_d = hold_data;
    hold_pc_d   = hold_pc;
    pc_if_d     = PC_IF;
    idata_d     = idata_IF;
    valid_d     = valid_IF;

    unique case (state)
      REQ: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
          if (ack) req_addr_d = target;
          else     state_d    = DRAIN;
        end else if (ack) begin
          if (!stall) begin
            pc_if_d    = req_addr;
            idata_d    = imem.imem_rdata;
            valid_d    = 1'b1;
            req_addr_d = req_addr + inc;
            pc_d       = req_addr + inc;
          end else begin
            hold_data_d = imem.imem_rdata;
            hold_pc_d   = req_addr;
            state_d     = HOLD;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end

      DRAIN: begin
        if (redirect || !stall) valid_d = 1'b0;
        // The old request finishes here; its data is wrong-path and dropped.
        if (ack) begin
          req_addr_d = redirect ? target : pc;
          pc_d       = redirect ? target : pc;
          state_d    = REQ;
        end else if (redirect) begin
          pc_d = target;
        end
      end

      HOLD: begin
        if (redirect) begin
          valid_d    = 1'b0;
          req_addr_d = target;
          pc_d       = target;
          state_d    = REQ;
        end else if (!stall) begin
          pc_if_d    = hold_pc;
          idata_d    = hold_data;
          valid_d    = 1'b1;
          req_addr_d = hold_pc + inc;
          pc_d       = hold_pc + inc;
          state_d    = REQ;
        end
      end

      default: state_d = REQ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= REQ;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      // NOTE: the hold buffer is a plain register pair, so it is cleared on
      // reset along with the outputs; no memory array is involved.
      hold_data <= '0;
      hold_pc   <= '0;
      PC_IF     <= '0;
      idata_IF  <= '0;
      valid_IF  <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      req_addr  <= req_addr_d;
      hold_data <= hold_data_d;
      hold_pc   <= hold_pc_d;
      PC_IF     <= pc_if_d;
      idata_IF  <= idata_d;
      valid_IF  <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table on zero-wait memory,
// plus hand sequences for wait states, redirect drain, PC wrap and async reset.
module tb_if_stage;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [31:0] pc_if, idata_if, w_pc_if, w_idata_if;
  logic        valid_if, w_valid_if;

  int lat = 0;
  int wait_cnt = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Main memory: acks after 'lat' wait cycles of a held request.
  if_stage_if #(.size(32)) bus ();
  assign bus.imem_ack   = bus.imem_req && (wait_cnt == lat);
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                          wait_cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else                                    wait_cnt <= 0;
  end

  if_stage #(.size(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(bus.master),
    .PC_IF(pc_if), .idata_IF(idata_if), .valid_IF(valid_if)
  );

  // Second instance with a top-of-memory reset PC on zero-wait memory.
  if_stage_if #(.size(32)) wbus ();
  assign wbus.imem_ack   = wbus.imem_req;
  assign wbus.imem_rdata = mem_word(wbus.imem_addr);

  if_stage #(.size(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .CLK(CLK), .RESET_N(RESET_N), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(wbus.master),
    .PC_IF(w_pc_if), .idata_IF(w_idata_if), .valid_IF(w_valid_if)
  );

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic q, input logic [31:0] a,
                              input logic v, input logic [31:0] p);
    vec_t t;
    t.stall = s; t.redirect = r; t.rpc = rpc;
    t.exp_req = q; t.exp_addr = a; t.exp_valid = v; t.exp_pc = p;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered at a negedge: drive inputs, check the request phase, clock, check outputs.
  task automatic step(input string tag, input logic s, input logic r, input logic [31:0] rpc,
                      input logic q, input logic [31:0] a,
                      input logic v, input logic [31:0] p);
    stall = s; redirect = r; redirect_pc = rpc;
    #1;
    check({tag, " imem_req"}, 32'(bus.imem_req), 32'(q));
    if (q) check({tag, " imem_addr"}, bus.imem_addr, a);
    @(posedge CLK); #1;
    check({tag, " valid_IF"}, 32'(valid_if), 32'(v));
    if (v) begin
      check({tag, " PC_IF"}, pc_if, p);
      check({tag, " idata_IF"}, idata_if, mem_word(p));
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 32'h0,   1, 32'h000, 1, 32'h000);
    vecs[1]  = mk(0, 0, 32'h0,   1, 32'h004, 1, 32'h004);
    vecs[2]  = mk(0, 0, 32'h0,   1, 32'h008, 1, 32'h008);
    vecs[3]  = mk(1, 0, 32'h0,   1, 32'h00C, 1, 32'h008);
    vecs[4]  = mk(1, 0, 32'h0,   0, 32'h000, 1, 32'h008);
    vecs[5]  = mk(0, 0, 32'h0,   0, 32'h000, 1, 32'h00C);
    vecs[6]  = mk(0, 0, 32'h0,   1, 32'h010, 1, 32'h010);
    vecs[7]  = mk(0, 1, 32'h103, 1, 32'h014, 0, 32'h000);
    vecs[8]  = mk(0, 0, 32'h0,   1, 32'h100, 1, 32'h100);
    vecs[9]  = mk(1, 1, 32'h40,  1, 32'h104, 0, 32'h000);
    vecs[10] = mk(1, 0, 32'h0,   1, 32'h040, 0, 32'h000);
    vecs[11] = mk(1, 1, 32'h203, 0, 32'h000, 0, 32'h000);
    vecs[12] = mk(0, 0, 32'h0,   1, 32'h200, 1, 32'h200);
    vecs[13] = mk(0, 0, 32'h0,   1, 32'h204, 1, 32'h204);

    // Reset state, sampled while reset is held.
    lat = 0;
    #2;
    check("reset imem_req", 32'(bus.imem_req), 32'h0);
    check("reset valid_IF", 32'(valid_if), 32'h0);
    check("reset PC_IF", pc_if, 32'h0);
    check("reset idata_IF", idata_if, 32'h0);

    // Wrap-around instance: 0xFFFFFFFC then 0x00000000.
    do_reset();
    #1;
    check("wrap imem_addr", wbus.imem_addr, 32'hFFFF_FFFC);
    @(posedge CLK); #1;
    check("wrap valid0", 32'(w_valid_if), 32'h1);
    check("wrap pc0", w_pc_if, 32'hFFFF_FFFC);
    check("wrap idata0", w_idata_if, mem_word(32'hFFFF_FFFC));
    @(posedge CLK); #1;
    check("wrap pc1", w_pc_if, 32'h0000_0000);
    check("wrap idata1", w_idata_if, mem_word(32'h0));

    // Zero-wait table: stream, stall into HOLD, redirects, redirect+stall in HOLD.
    do_reset();
    for (int i = 0; i < 14; i++)
      step($sformatf("vec%0d", i), vecs[i].stall, vecs[i].redirect, vecs[i].rpc,
           vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid, vecs[i].exp_pc);

    // Two-cycle memory: each address held for two cycles, bubble in between.
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++)
      step($sformatf("lat2_%0d", i), 0, 0, 32'h0, 1, 32'((i / 2) * 4),
           logic'(i % 2), 32'((i / 2) * 4));

    // Redirect to 0x100 while a request to 0x20 is outstanding.
    lat = 0;
    do_reset();
    step("drn_a", 0, 1, 32'h20, 1, 32'h000, 0, 32'h0);
    lat = 2;
    step("drn_b", 0, 1, 32'h100, 1, 32'h020, 0, 32'h0);
    step("drn_c", 0, 0, 32'h0,   1, 32'h020, 0, 32'h0);
    step("drn_d", 0, 0, 32'h0,   1, 32'h020, 0, 32'h0);
    lat = 0;
    step("drn_e", 0, 0, 32'h0,   1, 32'h100, 1, 32'h100);
    step("drn_f", 0, 0, 32'h0,   1, 32'h104, 1, 32'h104);

    // Async reset mid-stream, between clock edges.
    #2;
    RESET_N = 1'b0;
    #1;
    check("async imem_req", 32'(bus.imem_req), 32'h0);
    check("async valid_IF", 32'(valid_if), 32'h0);
    check("async PC_IF", pc_if, 32'h0);
    check("async idata_IF", idata_if, 32'h0);
    check("async w_valid_IF", 32'(w_valid_if), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
